buffer_out: RTL and testbench
=============================

// Module: buffer_out
// PURPOSE
//  Output side of the rescale IP. Accepts rescaled RGB565 pixels from the rescale core, holds them in a
//  small FIFO, and expands each one to a 32-bit RGB888 word on an AXI4-Stream master interface.
//  Asserts M_AXIS_TLAST on the last pixel of each output row and reports row and frame completion.
//  This block is the transmit counterpart of the input buffer.
// PARAMETERS
//  ROW_PIXELS  8   output pixels per row; TLAST is asserted on beat ROW_PIXELS-1 of each row
//  FRAME_ROWS  8   output rows per frame
//  FIFO_DEPTH  16  pixel FIFO entries; must be a power of 2
//  FIFO_AW     4   log2(FIFO_DEPTH)
// PORTS
//  clock          in   1   system clock; all logic on the rising edge
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   single-cycle pulse that begins a frame; honoured only in IDLE
//  pixel_in       in   16  rescaled pixel {R[4:0],G[5:0],B[4:0]}
//  pixel_valid    in   1   pixel_in is valid
//  pixel_ready    out  1   pixel_in is accepted on a rising edge when pixel_valid & pixel_ready
//  M_AXIS_TDATA   out  32  {8'h00, R8, G8, B8}
//  M_AXIS_TVALID  out  1   output beat valid
//  M_AXIS_TREADY  in   1   downstream ready
//  M_AXIS_TLAST   out  1   last beat of an output row
//  row_done_o     out  1   one-cycle pulse after each TLAST handshake
//  frame_done_o   out  1   one-cycle pulse when the last beat of the frame has completed
//  busy           out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset: applies immediately and asynchronously.
//   - state=IDLE; FIFO empty; all counters 0.
//   - Outputs: TVALID=0, TLAST=0, TDATA=0, pixel_ready=0, row_done_o=0, frame_done_o=0, busy=0.
//  Reset mid-frame: discards all queued data; no partial row is emitted.
//  FSM:
//   - IDLE -> ACTIVE on start.
//   - ACTIVE -> DRAIN on the edge that accepts pixel number ROW_PIXELS*FRAME_ROWS.
//   - DRAIN -> IDLE on the edge of the final beat handshake. frame_done_o pulses in the following cycle.
//   - start is ignored outside IDLE.
//  pixel_ready = (state==ACTIVE) & !fifo_full & (in_cnt < ROW_PIXELS*FRAME_ROWS).
//   - Not gated by pixel_valid, so there is no combinational path from valid to ready.
//  FIFO:
//   - Write pointer, read pointer and count, with FIFO_AW+1-bit count.
//   - Write happens on an accepted pixel.
//   - Read happens when the output register is empty or is being consumed that cycle (TVALID & TREADY).
//   - Simultaneous read and write keep the count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - A write when full is impossible because pixel_ready is 0.
//  Output register:
//   - TDATA, TVALID and TLAST are registered.
//   - Latency: a pixel accepted at edge N into an empty FIFO with an empty output register gives TVALID=1 after edge N+1.
//   - Throughput: 1 beat per cycle while TREADY=1.
//  AXI rule:
//   - Once TVALID=1, TDATA, TLAST and TVALID hold stable until TREADY=1.
//   - TVALID never drops without a handshake, except on reset.
//  Expansion:
//   - R8 = {R5, R5[4:2]}
//   - G8 = {G6, G6[5:4]}
//   - B8 = {B5, B5[4:2]}
//   - Bits [31:24] = 0
//  TLAST:
//   - Computed when a word loads into the output register.
//   - TLAST = 1 when out_col == ROW_PIXELS-1.
//  Beat counting:
//   - out_col increments per handshake and wraps to 0 after the TLAST handshake.
//   - out_row increments on each TLAST handshake.
//  Completion:
//   - row_done_o pulses in the cycle after every TLAST handshake, including the last row.
//   - frame_done_o coincides with the last row_done_o.
//  TREADY low with a full FIFO: pixel_ready=0 until space frees. No data is lost or duplicated.
//  pixel_valid outside ACTIVE: ignored. in_cnt is unchanged.
// TESTING
//  1. reset, start, 64 pixels with valid held high, TREADY=1 -> 64 beats; TLAST on beats 7,15,...,63;
//     8 row_done_o pulses; 1 frame_done_o; busy=0 afterwards.
//  2. pixel 16'hF800 then 16'h07E0 then 16'h001F -> TDATA 32'h00FF0000, 32'h0000FF00, 32'h000000FF;
//     16'h0000 -> 32'h00000000.
//  3. TREADY=0 for 30 cycles while pixels stream in -> pixel_ready=0 once 16 are queued plus 1 in the output register;
//     TDATA/TVALID stable throughout; on release all pixels emerge in order.
//  4. Random TREADY and pixel_valid patterns, 64-pixel frame -> beat order matches scoreboard;
//     TLAST only at column 7; no TVALID drop without handshake.
//  5. Assert reset mid-row 3 with TVALID=1 -> TVALID=0 immediately; busy=0; a following start and frame run clean.
//  6. start pulsed during ACTIVE and during DRAIN -> no effect; pixel_valid in IDLE -> nothing accepted, no beats emitted.

Source files
------------

// File: rtl/buffer_out.sv
// Output side of the rescale IP: RGB565 pixel FIFO feeding an RGB888 AXI4-Stream master.
// state | meaning: IDLE waiting for start; ACTIVE accepting pixels; DRAIN emitting queued beats.
module buffer_out #(
    parameter int ROW_PIXELS = 8,
    parameter int FRAME_ROWS = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST,
    output logic        row_done_o,
    output logic        frame_done_o,
    output logic        busy
);

    localparam int TOTAL = ROW_PIXELS * FRAME_ROWS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int COL_W = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
    localparam int ROW_W = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_count;
    logic [CNT_W-1:0]    r_in_cnt;
    logic [COL_W-1:0]    r_out_col;
    logic [COL_W-1:0]    w_col_nxt;
    logic [ROW_W-1:0]    r_out_row;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_rd;
    logic                w_hs;
    logic                w_hs_last;
    logic                w_frame_end;
    logic                w_ld_last;
    logic [15:0]         w_head;
    logic [31:0]         w_expanded;

    assign w_full      = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign pixel_ready = (r_state == S_ACTIVE) && !w_full && (r_in_cnt < CNT_W'(TOTAL));
    assign w_accept    = pixel_valid && pixel_ready;
    assign w_hs        = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_hs_last   = w_hs && M_AXIS_TLAST;
    assign w_frame_end = w_hs_last && (r_state == S_DRAIN) && (r_out_row == ROW_W'(FRAME_ROWS - 1));
    assign w_rd        = (!M_AXIS_TVALID || M_AXIS_TREADY) && !w_empty;
    assign busy        = (r_state != S_IDLE);

    assign w_head     = r_mem[r_rd_ptr];
    assign w_expanded = {8'h00,
                         w_head[15:11], w_head[15:13],
                         w_head[10:5],  w_head[10:9],
                         w_head[4:0],   w_head[4:2]};

    // Column of the word being loaded: out_col already advanced if the current beat completes now.
    always_comb begin
        w_col_nxt = r_out_col;
        if (w_hs) begin
            w_col_nxt = M_AXIS_TLAST ? '0 : r_out_col + COL_W'(1);
        end
    end
    assign w_ld_last = (w_col_nxt == COL_W'(ROW_PIXELS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_accept && (r_in_cnt == CNT_W'(TOTAL - 1))) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_frame_end) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_in_cnt <= '0;
        end else if (w_accept) begin
            r_in_cnt <= r_in_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= pixel_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_rd)     r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            unique case ({w_accept, w_rd})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            M_AXIS_TDATA  <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (w_rd) begin
            M_AXIS_TDATA  <= w_expanded;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= w_ld_last;
        end else if (w_hs) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_col    <= '0;
            r_out_row    <= '0;
            row_done_o   <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            r_out_col    <= w_col_nxt;
            row_done_o   <= w_hs_last;
            frame_done_o <= w_frame_end;
            if (w_frame_end) begin
                r_out_row <= '0;
            end else if (w_hs_last) begin
                r_out_row <= r_out_row + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_buffer_out.sv
// Randomized bench for buffer_out: a queue of expected RGB888 words plus beat/row bookkeeping.
module tb_buffer_out;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic        row_done_o;
    logic        frame_done_o;
    logic        busy;

    buffer_out dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .pixel_in      (pixel_in),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .row_done_o    (row_done_o),
        .frame_done_o  (frame_done_o),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RGB565 -> RGB888 by replicating the top bits into the vacated low bits.
    function automatic logic [31:0] expand(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return 32'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2)));
    endfunction

    logic [31:0] q[$];
    int          beat_cnt = 0;
    int          acc_cnt = 0;
    int          row_cnt = 0;
    int          frame_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        exp_row_done = 1'b0;
    logic        exp_frame_done = 1'b0;

    // Inputs change 1ns after the rising edge, so values seen here are the ones the next edge uses.
    always @(negedge clock) begin
        logic [31:0] exp_word;
        if (reset) begin
            q.delete();
            beat_cnt       = 0;
            acc_cnt        = 0;
            row_cnt        = 0;
            frame_cnt      = 0;
            prev_stall     = 1'b0;
            exp_row_done   = 1'b0;
            exp_frame_done = 1'b0;
        end else begin
            check("row_done", 32'(row_done_o), 32'(exp_row_done));
            check("frame_done", 32'(frame_done_o), 32'(exp_frame_done));
            if (row_done_o) row_cnt++;
            if (frame_done_o) frame_cnt++;
            if (!busy) check("ready_idle", 32'(pixel_ready), 32'd0);
            if (prev_stall) begin
                check("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
                check("hold_data", M_AXIS_TDATA, prev_data);
                check("hold_last", 32'(M_AXIS_TLAST), 32'(prev_last));
            end
            exp_row_done   = 1'b0;
            exp_frame_done = 1'b0;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                check("beat_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_word = q.pop_front();
                    check("tdata", M_AXIS_TDATA, exp_word);
                    check("tlast", 32'(M_AXIS_TLAST), 32'(beat_cnt % 8 == 7));
                    exp_row_done   = (beat_cnt % 8 == 7);
                    exp_frame_done = (beat_cnt % 64 == 63);
                    beat_cnt++;
                end
            end
            if (pixel_valid && pixel_ready) begin
                q.push_back(expand(pixel_in));
                acc_cnt++;
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_data  = M_AXIS_TDATA;
            prev_last  = M_AXIS_TLAST;
        end
    end

    int fr_acc_base, fr_beat_base, fr_row_base, fr_frame_base;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_frame();
        fr_acc_base   = acc_cnt;
        fr_beat_base  = beat_cnt;
        fr_row_base   = row_cnt;
        fr_frame_base = frame_cnt;
        pixel_valid   = 1'b0;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic finish_frame(input int vpct, input int rpct);
        int cyc = 0;
        while (frame_cnt == fr_frame_base && cyc < 4000) begin
            pixel_valid   = (acc_cnt - fr_acc_base < 64) && ($urandom_range(99) < vpct);
            pixel_in      = 16'($urandom);
            M_AXIS_TREADY = ($urandom_range(99) < rpct);
            tick();
            cyc++;
        end
        pixel_valid = 1'b0;
        check("frames_done", 32'(frame_cnt - fr_frame_base), 32'd1);
        check("frame_beats", 32'(beat_cnt - fr_beat_base), 32'd64);
        check("frame_rows", 32'(row_cnt - fr_row_base), 32'd8);
        check("frame_accepted", 32'(acc_cnt - fr_acc_base), 32'd64);
        check("busy_after", 32'(busy), 32'd0);
        check("queue_left", 32'(q.size()), 32'd0);
    endtask

    task automatic run_frame(input int vpct, input int rpct);
        begin_frame();
        finish_frame(vpct, rpct);
    endtask

    task automatic send_one(input logic [15:0] p, input logic [31:0] e);
        pixel_valid = 1'b1;
        pixel_in    = p;
        tick();
        pixel_valid = 1'b0;
        check("lat_edge_n", 32'(M_AXIS_TVALID), 32'd0);
        tick();
        check("lat_edge_n1", 32'(M_AXIS_TVALID), 32'd1);
        check("expand", M_AXIS_TDATA, e);
    endtask

    initial begin
        int cyc;
        int b0, a0;
        reset         = 1'b1;
        start         = 1'b0;
        pixel_valid   = 1'b0;
        pixel_in      = '0;
        M_AXIS_TREADY = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        check("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        check("rst_tdata", M_AXIS_TDATA, 32'd0);
        check("rst_ready", 32'(pixel_ready), 32'd0);
        check("rst_row_done", 32'(row_done_o), 32'd0);
        check("rst_frame_done", 32'(frame_done_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Full-rate frame.
        run_frame(100, 100);

        // Directed colour expansion and load latency.
        M_AXIS_TREADY = 1'b1;
        begin_frame();
        send_one(16'hF800, 32'h00FF0000);
        send_one(16'h07E0, 32'h0000FF00);
        send_one(16'h001F, 32'h000000FF);
        send_one(16'h0000, 32'h00000000);
        send_one(16'h8410, expand(16'h8410));
        finish_frame(80, 80);

        // Backpressure fills the FIFO plus the output register.
        begin_frame();
        M_AXIS_TREADY = 1'b0;
        repeat (30) begin
            pixel_valid = 1'b1;
            pixel_in    = 16'($urandom);
            tick();
        end
        check("stall_ready", 32'(pixel_ready), 32'd0);
        check("stall_accepted", 32'(acc_cnt - fr_acc_base), 32'd17);
        check("stall_tvalid", 32'(M_AXIS_TVALID), 32'd1);
        finish_frame(100, 100);

        // Random handshake patterns.
        run_frame(70, 60);
        run_frame(30, 90);
        run_frame(90, 20);

        // start during ACTIVE and during DRAIN.
        begin_frame();
        repeat (10) begin
            pixel_valid   = ($urandom_range(1) == 1);
            pixel_in      = 16'($urandom);
            M_AXIS_TREADY = ($urandom_range(1) == 1);
            tick();
        end
        pixel_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_active", 32'(busy), 32'd1);
        cyc = 0;
        while (acc_cnt - fr_acc_base < 64 && cyc < 1000) begin
            pixel_valid   = 1'b1;
            pixel_in      = 16'($urandom);
            M_AXIS_TREADY = 1'b1;
            tick();
            cyc++;
        end
        pixel_valid   = 1'b0;
        M_AXIS_TREADY = 1'b0;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        check("start_in_drain", 32'(busy), 32'd1);
        check("drain_ready", 32'(pixel_ready), 32'd0);
        finish_frame(0, 100);

        // pixel_valid while idle is ignored.
        b0 = beat_cnt;
        a0 = acc_cnt;
        M_AXIS_TREADY = 1'b1;
        repeat (10) begin
            pixel_valid = 1'b1;
            pixel_in    = 16'($urandom);
            tick();
        end
        pixel_valid = 1'b0;
        repeat (3) tick();
        check("idle_accepted", 32'(acc_cnt - a0), 32'd0);
        check("idle_beats", 32'(beat_cnt - b0), 32'd0);
        check("idle_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        run_frame(60, 70);

        // Reset in the middle of row 3.
        begin_frame();
        cyc = 0;
        while (beat_cnt - fr_beat_base < 27 && cyc < 500) begin
            pixel_valid   = (acc_cnt - fr_acc_base < 64);
            pixel_in      = 16'($urandom);
            M_AXIS_TREADY = 1'b1;
            tick();
            cyc++;
        end
        check("pre_rst_tvalid", 32'(M_AXIS_TVALID), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        check("mid_rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        check("mid_rst_tdata", M_AXIS_TDATA, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(pixel_ready), 32'd0);
        pixel_valid   = 1'b0;
        M_AXIS_TREADY = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("post_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        run_frame(75, 65);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
